// File: rtl/clock_strobe_gen_pkg.sv
// ---------------------------------------------------------------------------
// clock_strobe_gen_pkg
//   Shared constants and types for the multi-channel strobe generator.
//   CHANNEL_IDX_W : width of the config channel index
//   MAX_CHANNELS  : largest number of channels the index can address
//   MAX_ACC_WIDTH : widest accumulator/increment supported
//   cfg_t         : one config write record {channel, inc, bypass, clear}
//   isValidChannel: true when an index addresses an instantiated channel
// ---------------------------------------------------------------------------
package clock_strobe_gen_pkg;

    localparam int CHANNEL_IDX_W = 4;
    localparam int MAX_CHANNELS  = 16;
    localparam int MAX_ACC_WIDTH = 32;

    typedef struct packed {
        logic [CHANNEL_IDX_W-1:0] channel;
        logic [MAX_ACC_WIDTH-1:0] inc;
        logic                     bypass;
        logic                     clear;
    } cfg_t;

    // An index is only meaningful below the instantiated channel count;
    // anything above it must be rejected rather than aliased.
    function automatic logic isValidChannel(input logic [CHANNEL_IDX_W-1:0] ch,
                                            input int                       n);
        return ({{(32-CHANNEL_IDX_W){1'b0}}, ch} < 32'(n));
    endfunction

endpackage

// File: rtl/clock_strobe_gen_nco_channel.sv
// ---------------------------------------------------------------------------
// clock_strobe_gen_nco_channel
//   One phase-accumulator channel. Adds its increment every cycle while
//   running and emits a registered one-cycle strobe on each accumulator wrap.
//   refclk   : clock
//   reset    : async active-high reset
//   run_i    : settle interval complete; accumulator held at zero otherwise
//   load_i   : latch inc_i/bypass_i this edge
//   clear_i  : zero accumulator and strobe this edge (only with load_i)
//   sync_i   : zero accumulator and strobe this edge (global alignment)
//   inc_i    : new phase increment
//   bypass_i : new bypass mode (strobe every cycle)
//   strobe_o : registered clock-enable pulse
// ---------------------------------------------------------------------------
module clock_strobe_gen_nco_channel
    import clock_strobe_gen_pkg::*;
#(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 refclk,
    input  logic                 reset,
    input  logic                 run_i,
    input  logic                 load_i,
    input  logic                 clear_i,
    input  logic                 sync_i,
    input  logic [ACC_WIDTH-1:0] inc_i,
    input  logic                 bypass_i,
    output logic                 strobe_o
);

    logic [ACC_WIDTH-1:0] inc_q, inc_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 bypass_q, bypass_d;
    logic                 strobe_q, strobe_d;
    logic [ACC_WIDTH:0]   sum;

    // Next-state for one channel. A config write only changes the stored
    // increment, so the edge that latches it still accumulates with the old
    // value. Clear and sync both override accumulation but never the
    // register write itself, which lets a write and a sync land together.
    always_comb begin
        inc_d    = inc_q;
        bypass_d = bypass_q;
        acc_d    = acc_q;
        strobe_d = 1'b0;
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        if (!run_i) begin
            acc_d = '0;
        end else begin
            if (load_i) begin
                inc_d    = inc_i;
                bypass_d = bypass_i;
            end
            if (clear_i || sync_i) begin
                acc_d    = '0;
                strobe_d = 1'b0;
            end else if (bypass_q) begin
                strobe_d = 1'b1;
            end else begin
                acc_d    = sum[ACC_WIDTH-1:0];
                strobe_d = sum[ACC_WIDTH];
            end
        end
    end

    // Channel state registers; everything returns to zero on reset so a
    // channel is silent until it is explicitly configured again.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            inc_q    <= '0;
            acc_q    <= '0;
            bypass_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            inc_q    <= inc_d;
            acc_q    <= acc_d;
            bypass_q <= bypass_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/clock_strobe_gen.sv
// ---------------------------------------------------------------------------
// clock_strobe_gen
//   Multi-channel NCO clock-enable generator. A settle counter gates all
//   strobes after reset; channel rates are written through a valid/ready port.
//   refclk      : clock, rising edge
//   reset       : async active-high reset
//   cfg_valid   : config write request
//   cfg_ready   : config port accepting (equals ready)
//   cfg_channel : target channel index
//   cfg_inc     : new increment for the target channel
//   cfg_bypass  : target channel strobes every cycle
//   cfg_clear   : also zero the target accumulator
//   cfg_error   : one-cycle pulse after a write to a missing channel
//   sync        : zero all accumulators together
//   ready       : settle interval complete
//   strobe      : per-channel one-cycle enable pulses
// ---------------------------------------------------------------------------
module clock_strobe_gen
    import clock_strobe_gen_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int ACC_WIDTH     = 16,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                     refclk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CHANNEL_IDX_W-1:0] cfg_channel,
    input  logic [ACC_WIDTH-1:0]     cfg_inc,
    input  logic                     cfg_bypass,
    input  logic                     cfg_clear,
    output logic                     cfg_error,
    input  logic                     sync,
    output logic                     ready,
    output logic [CHANNELS-1:0]      strobe
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0]    settleCnt_q, settleCnt_d;
    logic                ready_q, ready_d;
    logic                cfgError_q, cfgError_d;
    logic                cfgAccept;
    logic                chanOk;
    logic                syncEn;
    logic [CHANNELS-1:0] loadVec;
    logic [CHANNELS-1:0] strobeVec;

    // Settle counter saturates at its last value; ready follows one cycle
    // after the counter gets there and then stays up until the next reset.
    always_comb begin
        settleCnt_d = settleCnt_q;
        if (settleCnt_q != SETTLE_LAST) begin
            settleCnt_d = settleCnt_q + 1'b1;
        end
        ready_d = ready_q | (settleCnt_q == SETTLE_LAST);
    end

    // A write is only taken while ready; a write that names a channel that
    // does not exist changes nothing and just raises the error pulse.
    assign cfgAccept  = cfg_valid & ready_q;
    assign chanOk     = isValidChannel(cfg_channel, CHANNELS);
    assign cfgError_d = cfgAccept & ~chanOk;
    assign syncEn     = sync & ready_q;

    // Top-level control registers.
    always_ff @(posedge refclk or posedge reset) begin
        if (reset) begin
            settleCnt_q <= '0;
            ready_q     <= 1'b0;
            cfgError_q  <= 1'b0;
        end else begin
            settleCnt_q <= settleCnt_d;
            ready_q     <= ready_d;
            cfgError_q  <= cfgError_d;
        end
    end

    // One accumulator per channel, each loaded only when the accepted write
    // decodes to its index.
    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        assign loadVec[i] = cfgAccept & chanOk &
                            (cfg_channel == CHANNEL_IDX_W'(i));

        clock_strobe_gen_nco_channel #(
            .ACC_WIDTH (ACC_WIDTH)
        ) uChan (
            .refclk   (refclk),
            .reset    (reset),
            .run_i    (ready_q),
            .load_i   (loadVec[i]),
            .clear_i  (loadVec[i] & cfg_clear),
            .sync_i   (syncEn),
            .inc_i    (cfg_inc),
            .bypass_i (cfg_bypass),
            .strobe_o (strobeVec[i])
        );
    end

    assign strobe    = strobeVec;
    assign ready     = ready_q;
    assign cfg_ready = ready_q;
    assign cfg_error = cfgError_q;

endmodule

// File: tb/tb_clock_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_strobe_gen
//   Self-checking bench for clock_strobe_gen with CHANNELS=4, ACC_WIDTH=16,
//   SETTLE_CYCLES=1024. Expected strobe patterns are derived by hand from the
//   accumulator arithmetic and queued per cycle, then popped as the DUT runs.
// ---------------------------------------------------------------------------
module tb_clock_strobe_gen;
    import clock_strobe_gen_pkg::*;

    localparam int CHANNELS  = 4;
    localparam int ACC_WIDTH = 16;
    localparam int SETTLE    = 1024;

    logic                     refclk;
    logic                     reset;
    logic                     cfg_valid;
    logic                     cfg_ready;
    logic [CHANNEL_IDX_W-1:0] cfg_channel;
    logic [ACC_WIDTH-1:0]     cfg_inc;
    logic                     cfg_bypass;
    logic                     cfg_clear;
    logic                     cfg_error;
    logic                     sync;
    logic                     ready;
    logic [CHANNELS-1:0]      strobe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        cfg_t        cfg;
        logic [15:0] pattern;
        string       name;
    } vec_t;

    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [3:0]  expected;
    } sbEntry_t;

    vec_t     vectors[6];
    sbEntry_t sbQ[$];

    clock_strobe_gen #(
        .CHANNELS      (CHANNELS),
        .ACC_WIDTH     (ACC_WIDTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .refclk      (refclk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_channel (cfg_channel),
        .cfg_inc     (cfg_inc),
        .cfg_bypass  (cfg_bypass),
        .cfg_clear   (cfg_clear),
        .cfg_error   (cfg_error),
        .sync        (sync),
        .ready       (ready),
        .strobe      (strobe)
    );

    // Free-running 100 MHz reference clock.
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    function automatic vec_t mkVec(input logic [3:0] ch, input logic [31:0] inc,
                                   input logic bp, input logic [15:0] pat,
                                   input string nm);
        vec_t v;
        v.cfg.channel = ch;
        v.cfg.inc     = inc;
        v.cfg.bypass  = bp;
        v.cfg.clear   = 1'b1;
        v.pattern     = pat;
        v.name        = nm;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    // One-cycle config write; returns 1 ns after the edge that took it.
    task automatic applyStimulus(input cfg_t c);
        cfg_valid   = 1'b1;
        cfg_channel = c.channel;
        cfg_inc     = c.inc[ACC_WIDTH-1:0];
        cfg_bypass  = c.bypass;
        cfg_clear   = c.clear;
        step();
        cfg_valid   = 1'b0;
        cfg_clear   = 1'b0;
    endtask

    task automatic pushPattern(input string name, input logic [3:0] mask,
                               input logic [15:0] pat);
        sbEntry_t e;
        for (int k = 0; k < 16; k++) begin
            e.name     = name;
            e.mask     = mask;
            e.expected = pat[k] ? mask : 4'h0;
            sbQ.push_back(e);
        end
    endtask

    task automatic drainScoreboard();
        sbEntry_t e;
        while (sbQ.size() > 0) begin
            step();
            e = sbQ.pop_front();
            checkOutput(e.name, 32'(strobe & e.mask), 32'(e.expected));
        end
    endtask

    // Counts cycles after reset release; ready and cfg_ready must stay low
    // for 1023 edges and rise on edge 1024.
    task automatic waitSettle(input string tag);
        int earlyHigh;
        earlyHigh = 0;
        for (int k = 1; k < SETTLE; k++) begin
            step();
            if (ready !== 1'b0 || cfg_ready !== 1'b0) earlyHigh++;
        end
        checkOutput({tag, "ReadyLowDuringSettle"}, 32'(earlyHigh), 32'd0);
        step();
        checkOutput({tag, "ReadyAtSettle"}, 32'(ready), 32'd1);
        checkOutput({tag, "CfgReadyAtSettle"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        cfg_t     c;
        sbEntry_t e;
        int       cnt;

        vectors[0] = mkVec(4'd0, 32'h4000, 1'b0, 16'h8888, "ch0Inc4000");
        vectors[1] = mkVec(4'd0, 32'h5556, 1'b0, 16'h4924, "ch0Inc5556");
        vectors[2] = mkVec(4'd1, 32'h0000, 1'b1, 16'hFFFF, "ch1Bypass");
        vectors[3] = mkVec(4'd2, 32'h0000, 1'b0, 16'h0000, "ch2IncZero");
        vectors[4] = mkVec(4'd3, 32'h8000, 1'b0, 16'hAAAA, "ch3Inc8000");
        vectors[5] = mkVec(4'd0, 32'hFFFF, 1'b0, 16'hFFFE, "ch0IncFFFF");

        reset       = 1'b1;
        cfg_valid   = 1'b0;
        cfg_channel = '0;
        cfg_inc     = '0;
        cfg_bypass  = 1'b0;
        cfg_clear   = 1'b0;
        sync        = 1'b0;
        step();
        step();
        checkOutput("rstReady", 32'(ready), 32'd0);
        checkOutput("rstCfgReady", 32'(cfg_ready), 32'd0);
        checkOutput("rstCfgError", 32'(cfg_error), 32'd0);
        checkOutput("rstStrobe", 32'(strobe), 32'd0);

        // A write held during settle must never be taken.
        cfg_valid   = 1'b1;
        cfg_channel = 4'd0;
        cfg_inc     = 16'hFFFF;
        cfg_bypass  = 1'b1;
        reset       = 1'b0;
        waitSettle("init");
        cfg_valid   = 1'b0;
        cfg_bypass  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            e.name = "noEarlyWrite"; e.mask = 4'hF; e.expected = 4'h0;
            sbQ.push_back(e);
        end
        drainScoreboard();

        // Table-driven single-channel rate checks, each starting from a clear.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vectors[v].cfg);
            checkOutput({vectors[v].name, "NoErr"}, 32'(cfg_error), 32'd0);
            pushPattern(vectors[v].name, 4'(1 << vectors[v].cfg.channel),
                        vectors[v].pattern);
            drainScoreboard();
        end

        // inc=0x5556 gives three strobes per nine cycles: 30 in 90.
        c = '{channel: 4'd0, inc: 32'h5556, bypass: 1'b0, clear: 1'b1};
        applyStimulus(c);
        cnt = 0;
        for (int k = 0; k < 90; k++) begin
            step();
            if (strobe[0] === 1'b1) cnt++;
        end
        checkOutput("ch0Rate5556", 32'(cnt), 32'd30);

        // Sync alignment of two free-running channels.
        c = '{channel: 4'd0, inc: 32'h4000, bypass: 1'b0, clear: 1'b1};
        applyStimulus(c);
        c = '{channel: 4'd1, inc: 32'h2000, bypass: 1'b0, clear: 1'b1};
        applyStimulus(c);
        step(); step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checkOutput("syncEdgeZero", 32'(strobe), 32'd0);
        for (int k = 0; k < 16; k++) begin
            e.name     = "syncAlign";
            e.mask     = 4'b0011;
            e.expected = {2'b00, (k % 8 == 7), (k % 4 == 3)};
            sbQ.push_back(e);
        end
        drainScoreboard();

        // Write to a missing channel: error pulse only.
        c = '{channel: 4'd7, inc: 32'h1234, bypass: 1'b1, clear: 1'b1};
        applyStimulus(c);
        checkOutput("badChanError", 32'(cfg_error), 32'd1);
        step();
        checkOutput("badChanErrorPulse", 32'(cfg_error), 32'd0);

        // Sync together with a write to ch3: new inc taken, all phases zeroed.
        sync = 1'b1;
        c = '{channel: 4'd3, inc: 32'h4000, bypass: 1'b0, clear: 1'b0};
        applyStimulus(c);
        sync = 1'b0;
        checkOutput("syncWriteZero", 32'(strobe), 32'd0);
        for (int k = 0; k < 16; k++) begin
            e.name     = "syncWrite";
            e.mask     = 4'hF;
            e.expected = {(k % 4 == 3), 1'b0, (k % 8 == 7), (k % 4 == 3)};
            sbQ.push_back(e);
        end
        drainScoreboard();

        // Asynchronous reset mid-stream while ch1 strobes continuously.
        c = '{channel: 4'd1, inc: 32'h0000, bypass: 1'b1, clear: 1'b1};
        applyStimulus(c);
        step();
        checkOutput("preResetBypass", 32'(strobe[1]), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("asyncRstStrobe", 32'(strobe), 32'd0);
        checkOutput("asyncRstReady", 32'(ready), 32'd0);
        checkOutput("asyncRstCfgReady", 32'(cfg_ready), 32'd0);
        step();
        reset = 1'b0;
        waitSettle("reRst");
        for (int k = 0; k < 32; k++) begin
            e.name = "postRstSilent"; e.mask = 4'hF; e.expected = 4'h0;
            sbQ.push_back(e);
        end
        drainScoreboard();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
